// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage (master) and data memory (slave).
// Request/ack handshake; rdata is valid in the same cycle as ack.
interface mem_access_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through, runs big-endian loads/stores on the data bus.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of masking.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   ex_wd,
    input  logic         ex_wreg,
    input  logic [31:0]  ex_wdata,
    input  logic [3:0]   ex_memop,
    input  logic [31:0]  ex_addr,
    input  logic [31:0]  ex_sdata,
    output logic [4:0]   mem_wd,
    output logic         mem_wreg,
    output logic [31:0]  mem_wdata,
    output logic         stallreq,
    mem_access_if.master dbus,
    output logic         mem_buserr,
    output logic         mem_misalign
);
    localparam logic [3:0] OpLb = 4'd1, OpLbu = 4'd2, OpLh = 4'd3, OpLhu = 4'd4, OpLw = 4'd5;
    localparam logic [3:0] OpSb = 4'd6, OpSh = 4'd7, OpSw = 4'd8;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(ACK_TIMEOUT);
    localparam bit               TimeoutEn  = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req, r_we, r_buserr;
    logic [31:0]      r_addr, r_wdata, r_rdata;
    logic [3:0]       r_sel;

    logic        w_is_load, w_is_store, w_is_byte, w_is_half, w_is_word;
    logic        w_misalign, w_start;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;

    assign w_is_load  = (ex_memop >= OpLb) && (ex_memop <= OpLw);
    assign w_is_store = (ex_memop >= OpSb) && (ex_memop <= OpSw);
    assign w_is_byte  = (ex_memop == OpLb) || (ex_memop == OpLbu) || (ex_memop == OpSb);
    assign w_is_half  = (ex_memop == OpLh) || (ex_memop == OpLhu) || (ex_memop == OpSh);
    assign w_is_word  = (ex_memop == OpLw) || (ex_memop == OpSw);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (w_is_half && ex_addr[0]) || (w_is_word && (ex_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_start = (w_is_load || w_is_store) && !w_misalign;

    // Lane selection ignores sub-natural address bits, which masks misalignment.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = ex_sdata;
        if (w_is_byte) begin
            w_sel   = 4'b1000 >> ex_addr[1:0];
            w_wdata = {4{ex_sdata[7:0]}};
        end else if (w_is_half) begin
            w_sel   = ex_addr[1] ? 4'b0011 : 4'b1100;
            w_wdata = {2{ex_sdata[15:0]}};
        end
    end

    always_comb begin
        unique case (ex_addr[1:0])
            2'd0:    w_load_byte = r_rdata[31:24];
            2'd1:    w_load_byte = r_rdata[23:16];
            2'd2:    w_load_byte = r_rdata[15:8];
            default: w_load_byte = r_rdata[7:0];
        endcase
        w_load_half = ex_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
        case (ex_memop)
            OpLb:    w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
            OpLbu:   w_load_data = {24'd0, w_load_byte};
            OpLh:    w_load_data = {{16{w_load_half[15]}}, w_load_half};
            OpLhu:   w_load_data = {16'd0, w_load_half};
            default: w_load_data = r_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_sel    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_buserr <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_buserr <= 1'b0;
                    r_cnt    <= '0;
                    if (w_start) begin
                        r_state <= StBusy;
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {ex_addr[31:2], 2'b00};
                        r_sel   <= w_sel;
                        r_wdata <= w_wdata;
                    end
                end
                StBusy: begin
                    // An ack on the deadline edge still wins over the timeout.
                    if (dbus.dbus_ack) begin
                        r_rdata <= dbus.dbus_rdata;
                        r_req   <= 1'b0;
                        r_state <= StDone;
                    end else if (TimeoutEn && (r_cnt + 1'b1 == TimeoutVal)) begin
                        r_req    <= 1'b0;
                        r_buserr <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_buserr <= 1'b0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        mem_wd       = '0;
        mem_wreg     = 1'b0;
        mem_wdata    = '0;
        stallreq     = 1'b0;
        mem_misalign = 1'b0;
        if (rst) begin
            mem_wd    = ex_wd;
            mem_wdata = ex_wdata;
            case (r_state)
                StIdle: begin
                    stallreq     = w_start;
                    mem_misalign = w_misalign;
                    mem_wreg     = ex_wreg && !w_is_load && !w_is_store;
                end
                StBusy: stallreq = 1'b1;
                default: begin
                    if (w_is_load && !r_buserr) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = w_load_data;
                    end
                end
            endcase
        end
    end

    assign dbus.dbus_req   = r_req;
    assign dbus.dbus_we    = r_we;
    assign dbus.dbus_addr  = r_addr;
    assign dbus.dbus_sel   = r_sel;
    assign dbus.dbus_wdata = r_wdata;
    assign mem_buserr      = r_buserr;
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a byte-array reference of big-endian bus accesses.
module tb_mem_access;
    localparam int Timeout = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_addr = '0, ex_sdata = '0;
    logic [3:0]  ex_memop = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, stallreq, mem_buserr, mem_misalign;
    logic [31:0] mem_wdata;
    int          n_checks = 0;
    int          n_pass = 0;

    mem_access_if dbus_if ();

    mem_access #(.ACK_TIMEOUT(Timeout), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_memop    (ex_memop),
        .ex_addr     (ex_addr),
        .ex_sdata    (ex_sdata),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .stallreq    (stallreq),
        .dbus        (dbus_if),
        .mem_buserr  (mem_buserr),
        .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int op_size(input logic [3:0] op);
        if (op == 1 || op == 2 || op == 6) return 1;
        if (op == 3 || op == 4 || op == 7) return 2;
        if (op == 5 || op == 8) return 4;
        return 0;
    endfunction

    // Byte lanes touched, big-endian: lane i lives in bits [31-8i -: 8], sel bit 3-i.
    function automatic logic [3:0] model_sel(input int size, input logic [31:0] addr);
        logic [3:0] s = '0;
        int first = (int'(addr % 4) / size) * size;
        for (int i = first; i < first + size; i++) s[3-i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input int size, input logic [31:0] sdata);
        longint val = longint'(sdata) % (64'd1 << (8 * size));
        longint res = 0;
        for (int k = 0; k < 4 / size; k++) res = (res << (8 * size)) | val;
        return 32'(res);
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] rdata,
                                               input logic [31:0] addr);
        int     size = op_size(op);
        int     first = (int'(addr % 4) / size) * size;
        longint val = 0;
        for (int i = first; i < first + size; i++)
            val = val * 256 + ((longint'(rdata) >> (8 * (3 - i))) % 256);
        if ((op == 1 || op == 3) && val >= (64'd1 << (8 * size - 1)))
            val = val - (64'd1 << (8 * size));
        return 32'(val);
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                         input int ack_cyc, input logic [31:0] rdata, input logic late_ack);
        int  size = op_size(op);
        bit  is_store = (op >= 6 && op <= 8);
        bit  is_load = (size != 0) && !is_store;
        bit  acked = 0;
        @(negedge clk);
        ex_memop = op; ex_addr = addr; ex_sdata = sdata; ex_wdata = wdata;
        ex_wd = wd; ex_wreg = wreg;
        dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = $urandom;
        #1;
        check("idle_wd", 32'(mem_wd), 32'(wd));
        check("idle_buserr", 32'(mem_buserr), 0);
        check("idle_req", 32'(dbus_if.dbus_req), 0);
        if (size == 0) begin
            check("alu_wreg", 32'(mem_wreg), 32'(wreg));
            check("alu_wdata", mem_wdata, wdata);
            check("alu_stall", 32'(stallreq), 0);
            check("alu_misalign", 32'(mem_misalign), 0);
            return;
        end
`ifdef MEM_ALIGN_CHECK_EN
        if (addr % size != 0) begin
            check("mis_flag", 32'(mem_misalign), 1);
            check("mis_stall", 32'(stallreq), 0);
            check("mis_wreg", 32'(mem_wreg), 0);
            @(negedge clk);
            #1;
            check("mis_noreq", 32'(dbus_if.dbus_req), 0);
            return;
        end
`endif
        check("idle_stall", 32'(stallreq), 1);
        check("idle_misalign", 32'(mem_misalign), 0);
        for (int k = 1; k <= Timeout; k++) begin
            @(negedge clk);
            dbus_if.dbus_ack = (k == ack_cyc);
            dbus_if.dbus_rdata = rdata;
            #1;
            check("busy_req", 32'(dbus_if.dbus_req), 1);
            check("busy_stall", 32'(stallreq), 1);
            check("busy_we", 32'(dbus_if.dbus_we), 32'(is_store));
            check("busy_addr", dbus_if.dbus_addr, addr - (addr % 4));
            check("busy_sel", 32'(dbus_if.dbus_sel), 32'(model_sel(size, addr)));
            if (is_store) check("busy_wdata", dbus_if.dbus_wdata, model_wdata(size, sdata));
            if (k == ack_cyc) begin
                acked = 1;
                break;
            end
        end
        @(negedge clk);
        dbus_if.dbus_ack = late_ack;
        dbus_if.dbus_rdata = $urandom;
        #1;
        check("done_req", 32'(dbus_if.dbus_req), 0);
        check("done_stall", 32'(stallreq), 0);
        check("done_buserr", 32'(mem_buserr), 32'(!acked));
        check("done_wreg", 32'(mem_wreg), 32'(is_load && acked && wreg));
        if (is_load && acked) check("done_wdata", mem_wdata, model_load(op, rdata, addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dbus_if.dbus_ack = 1'b0;
        dbus_if.dbus_rdata = '0;
        ex_memop = 4'd5; ex_wreg = 1'b1; ex_wd = 5'd7; ex_wdata = 32'hDEAD_BEEF;
        #12;
        check("rst_wd", 32'(mem_wd), 0);
        check("rst_wreg", 32'(mem_wreg), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_stall", 32'(stallreq), 0);
        check("rst_req", 32'(dbus_if.dbus_req), 0);
        check("rst_buserr", 32'(mem_buserr), 0);
        check("rst_misalign", 32'(mem_misalign), 0);
        ex_memop = 4'd0;
        @(negedge clk);
        rst = 1'b1;

        do_op(4'd0, 32'h0, 32'h0, 32'h55, 5'd3, 1'b1, 0, 32'h0, 1'b0);
        do_op(4'd1, 32'h101, 32'h0, 32'h0, 5'd5, 1'b1, 2, 32'h1280_FF00, 1'b0);
        do_op(4'd7, 32'h202, 32'h0000_BEEF, 32'h0, 5'd6, 1'b1, 1, 32'h0, 1'b1);
        do_op(4'd5, 32'h300, 32'h0, 32'h0, 5'd8, 1'b1, 99, 32'h0, 1'b0);
        do_op(4'd5, 32'h103, 32'h0, 32'h0, 5'd9, 1'b1, 1, 32'hCAFE_F00D, 1'b0);
        do_op(4'd4, 32'h3FE, 32'h0, 32'h0, 5'd10, 1'b1, 4, 32'h1234_8765, 1'b0);

        // Reset asserted while the bus transaction is outstanding.
        @(negedge clk);
        ex_memop = 4'd5; ex_addr = 32'h200; ex_wreg = 1'b1;
        @(negedge clk);
        #1;
        check("mid_req_before", 32'(dbus_if.dbus_req), 1);
        rst = 1'b0;
        #1;
        check("mid_req_rst", 32'(dbus_if.dbus_req), 0);
        check("mid_stall_rst", 32'(stallreq), 0);
        @(negedge clk);
        rst = 1'b1; ex_memop = 4'd0; dbus_if.dbus_ack = 1'b1;
        #1;
        check("late_ack_stall", 32'(stallreq), 0);
        @(negedge clk);
        dbus_if.dbus_ack = 1'b0;
        #1;
        check("late_ack_req", 32'(dbus_if.dbus_req), 0);
        check("late_ack_buserr", 32'(mem_buserr), 0);
        do_op(4'd5, 32'h200, 32'h0, 32'h0, 5'd11, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 8));
            do_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(1, 6), $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
